// File: rtl/vga_pkg.sv
// vga_pkg: constants shared across the VGA test-pattern slice.
//   - 1024x768@60 timing (65 MHz pixel clock): line/frame periods and the
//     active-area (display-enable) bounds used by the pattern generator.
//   - Display-mode encodings selected by the key1 push-button.
//   - Debounce FSM state encoding and a small elaboration helper.
package vga_pkg;

  // Horizontal timing in pixel clocks: sync 136, back porch 160, active 1024, front porch 24.
  localparam int LinePeriod  = 1344;
  localparam int HdeStart    = 296;
  localparam int HdeEnd      = 1320;

  // Vertical timing in lines: sync 6, back porch 29, active 768, front porch 3.
  localparam int FramePeriod = 806;
  localparam int VdeStart    = 35;
  localparam int VdeEnd      = 803;

  // Display-mode encodings understood by the pattern selector.
  localparam logic [3:0] MODE_BLACK   = 4'd0;
  localparam logic [3:0] MODE_WHITE   = 4'd1;
  localparam logic [3:0] MODE_RED     = 4'd2;
  localparam logic [3:0] MODE_GREEN   = 4'd3;
  localparam logic [3:0] MODE_BLUE    = 4'd4;
  localparam logic [3:0] MODE_HGRAD   = 4'd5;
  localparam logic [3:0] MODE_VGRAD   = 4'd6;
  localparam logic [3:0] MODE_CHECKER = 4'd7;
  localparam logic [3:0] MODE_GRID    = 4'd8;
  localparam logic [3:0] MODE_HLINES  = 4'd9;
  localparam logic [3:0] MODE_VLINES  = 4'd10;
  localparam logic [3:0] MODE_BORDER  = 4'd11;
  localparam logic [3:0] MODE_BAR     = 4'd12;
  localparam logic [3:0] MODE_MAX     = 4'd13;

  // Key debounce FSM states.
  typedef enum logic [1:0] {
    KEY_IDLE     = 2'd0,
    KEY_PRESS_DB = 2'd1,
    KEY_HELD     = 2'd2,
    KEY_REL_DB   = 2'd3
  } key_state_e;

  // Larger of two elaboration-time integers (used to size shared counters).
  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises the raw active-low key and debounces it in both
// directions.
// Ports:
//   clk        in   vga_clk
//   rstn       in   asynchronous active-low reset
//   key_n      in   raw push-button, 0 = pressed, asynchronous to clk
//   press_step out  one-cycle pulse on the cycle a press is accepted
//   held       out  high while the key is accepted as held (HELD state)
module key_debounce
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 90000
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_n,
  output logic press_step,
  output logic held
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0]  DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q;
  logic             key_s_q;
  key_state_e       state_q;
  key_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_step_d;

  // Two-flop synchroniser; resets to the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      key_s_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      key_s_q <= sync1_q;
    end
  end

  // FSM state and debounce counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= KEY_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the step is issued on the same cycle the press debounce completes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    press_step_d = 1'b0;
    case (state_q)
      KEY_IDLE: begin
        if (!key_s_q) begin
          state_d = KEY_PRESS_DB;
          cnt_d   = '0;
        end else begin
          state_d = KEY_IDLE;
        end
      end
      KEY_PRESS_DB: begin
        if (key_s_q) begin
          // Released before the debounce window elapsed: treat as bounce.
          state_d = KEY_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d      = KEY_HELD;
          cnt_d        = '0;
          press_step_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      KEY_HELD: begin
        if (key_s_q) begin
          state_d = KEY_REL_DB;
          cnt_d   = '0;
        end else begin
          state_d = KEY_HELD;
        end
      end
      KEY_REL_DB: begin
        if (!key_s_q) begin
          // Release bounce: back to HELD without issuing another step.
          state_d = KEY_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = KEY_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = KEY_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign press_step = press_step_d;
  assign held       = (state_q == KEY_HELD);

endmodule

// File: rtl/vga_mode_sel.sv
// vga_mode_sel: turns the key1 push-button into the committed display mode.
// A wrapping counter (next_mode) advances once per accepted press; its value
// is copied to mode only on frame_start so the pattern never changes mid-frame.
// Optional feature macro: VGA_MODE_AUTO_REPEAT_EN -- when defined, holding the
// key issues a step after HOLD_CYC cycles and then every REPEAT_CYC cycles.
// Ports:
//   clk          in   vga_clk (65 MHz)
//   rstn         in   asynchronous active-low reset
//   key_n        in   raw push-button, 0 = pressed, asynchronous
//   frame_start  in   one-cycle pulse at the first line of each frame
//   mode         out  committed display mode [MODE_W]
//   mode_pending out  high while next_mode differs from mode
//   mode_changed out  one-cycle pulse after a commit that changed mode
module vga_mode_sel
  import vga_pkg::*;
#(
  parameter int MODE_W       = 4,
  parameter int MODE_MAX     = int'(vga_pkg::MODE_MAX),
  parameter int DEBOUNCE_CYC = 90000,
  parameter int HOLD_CYC     = 32500000,
  parameter int REPEAT_CYC   = 13000000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              key_n,
  input  logic              frame_start,
  output logic [MODE_W-1:0] mode,
  output logic              mode_pending,
  output logic              mode_changed
);

  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(MODE_MAX);

  // Reject configurations the counters cannot represent.
  if (DEBOUNCE_CYC < 2 || HOLD_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_cfg
    $error("vga_mode_sel: DEBOUNCE_CYC must be >= 2, HOLD_CYC and REPEAT_CYC >= 1");
  end

  // Wrapping increment of the mode number.
  function automatic logic [MODE_W-1:0] mode_inc(input logic [MODE_W-1:0] cur);
    if (cur == MODE_LAST) begin
      return '0;
    end else begin
      return cur + 1'b1;
    end
  endfunction

  logic              press_step;
  logic              held;
  logic              repeat_step;
  logic              step_s;
  logic [MODE_W-1:0] next_mode_q;
  logic [MODE_W-1:0] next_mode_d;
  logic [MODE_W-1:0] mode_q;
  logic [MODE_W-1:0] mode_d;
  logic              mode_changed_q;
  logic              mode_changed_d;

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_key_debounce (
    .clk        (clk),
    .rstn       (rstn),
    .key_n      (key_n),
    .press_step (press_step),
    .held       (held)
  );

`ifdef VGA_MODE_AUTO_REPEAT_EN
  localparam int               HOLD_W   = $clog2(max_int(HOLD_CYC, REPEAT_CYC) + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYC - 1);

  logic [HOLD_W-1:0] hold_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_d;
  logic              rpt_q;
  logic              rpt_d;
  logic              repeat_step_d;

  // Hold counter and repeat-phase flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_cnt_q <= '0;
      rpt_q      <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      rpt_q      <= rpt_d;
    end
  end

  // Auto-repeat: first step after HOLD_CYC cycles in HELD, then every REPEAT_CYC.
  // A fresh press clears the count; returning to HELD from a release bounce keeps it.
  always_comb begin
    hold_cnt_d    = hold_cnt_q;
    rpt_d         = rpt_q;
    repeat_step_d = 1'b0;
    if (press_step) begin
      hold_cnt_d = '0;
      rpt_d      = 1'b0;
    end else if (held) begin
      if (!rpt_q) begin
        if (hold_cnt_q == HOLD_LAST) begin
          repeat_step_d = 1'b1;
          rpt_d         = 1'b1;
          hold_cnt_d    = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end else begin
        if (hold_cnt_q == REP_LAST) begin
          repeat_step_d = 1'b1;
          hold_cnt_d    = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  assign repeat_step = repeat_step_d;
`else
  assign repeat_step = 1'b0;
`endif

  assign step_s = press_step | repeat_step;

  // Mode counter, committed mode and change pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      next_mode_q    <= '0;
      mode_q         <= '0;
      mode_changed_q <= 1'b0;
    end else begin
      next_mode_q    <= next_mode_d;
      mode_q         <= mode_d;
      mode_changed_q <= mode_changed_d;
    end
  end

  // Steps accumulate in next_mode; a commit samples the pre-step value, so a
  // step coinciding with frame_start lands at the following frame.
  always_comb begin
    next_mode_d    = next_mode_q;
    mode_d         = mode_q;
    mode_changed_d = 1'b0;
    if (step_s) begin
      next_mode_d = mode_inc(next_mode_q);
    end else begin
      next_mode_d = next_mode_q;
    end
    if (frame_start) begin
      mode_d         = next_mode_q;
      mode_changed_d = (next_mode_q != mode_q);
    end else begin
      mode_d         = mode_q;
      mode_changed_d = 1'b0;
    end
  end

  assign mode         = mode_q;
  assign mode_changed = mode_changed_q;
  assign mode_pending = (next_mode_q != mode_q);

endmodule
